// File: rtl/mem_dispatcher_pkg.sv
// ---------------------------------------------------------------------------
// mem_dispatcher_pkg
//
// Shared definitions for the DDR2 line dispatchers that sit on MCB user ports
// in the c3_clk0 domain: MCB command codes, the line writer state encoding
// and the word size used for byte address arithmetic.
// ---------------------------------------------------------------------------
package mem_dispatcher_pkg;

    // MCB user-port command instruction codes
    localparam logic [2:0] MCB_INSTR_WR = 3'b000;
    localparam logic [2:0] MCB_INSTR_RD = 3'b001;

    // Each line-buffer word is 32 bits, so consecutive words are 4 bytes apart
    localparam int BYTES_PER_WORD = 4;

    // Line writer control states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_CAL,
        ST_PRIME,
        ST_FILL,
        ST_CMD
    } writer_state_t;

endpackage

// File: rtl/mem_line_writer.sv
// ---------------------------------------------------------------------------
// mem_line_writer
//
// Moves one video line of WORDS_TO_WRITE 32-bit words from an on-chip line
// buffer into DDR2 through one MCB user port. Words are pushed into the MCB
// write FIFO in bursts of up to FIFO_LENGTH words, and one write command is
// issued after each burst. The final burst carries the remainder when the
// line length is not a multiple of FIFO_LENGTH.
//
// Ports:
//   clk                 MCB user clock (c3_clk0), single clock domain
//   reset               synchronous, active-high
//   os_start            one-shot start pulse, honoured only while idle
//   init_mem_addr       DDR byte address of word 0 (bits [1:0] ignored)
//   busy_unit           high from accepted start until the last command
//   data_in__addr       line-buffer read address (buffer has 1-cycle latency)
//   data_in             line-buffer read data
//   mem_calib_done      MCB calibration complete
//   port_cmd_en         MCB command strobe
//   port_cmd_instr      MCB instruction, always write
//   port_cmd_bl         burst length minus one
//   port_cmd_byte_addr  burst start byte address
//   port_wr_en          MCB write FIFO push
//   port_wr_data_out    MCB write FIFO data
//   port_wr_full        MCB write FIFO full
//   stall_cycles        (MEM_LINE_WRITER_STATS_EN only) saturating count of
//                       fill cycles lost to a full write FIFO
//
// Build option: define MEM_LINE_WRITER_STATS_EN to add the stall counter.
// ---------------------------------------------------------------------------
module mem_line_writer
    import mem_dispatcher_pkg::*;
#(
    parameter int FIFO_LENGTH    = 64,
    parameter int WORDS_TO_WRITE = 640,
    parameter int BUFF_ADDR_BITS = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      os_start,
    input  logic [29:0]               init_mem_addr,
    output logic                      busy_unit,
    output logic [BUFF_ADDR_BITS-1:0] data_in__addr,
    input  logic [31:0]               data_in,
    input  logic                      mem_calib_done,
    output logic                      port_cmd_en,
    output logic [2:0]                port_cmd_instr,
    output logic [5:0]                port_cmd_bl,
    output logic [29:0]               port_cmd_byte_addr,
    output logic                      port_wr_en,
    output logic [31:0]               port_wr_data_out,
    input  logic                      port_wr_full
`ifdef MEM_LINE_WRITER_STATS_EN
    ,
    output logic [15:0]               stall_cycles
`endif
);

    // Word counter must be able to hold the full line length itself
    localparam int WCW = $clog2(WORDS_TO_WRITE + 1);
    localparam logic [WCW-1:0] WORDS_LAST = WCW'(WORDS_TO_WRITE);
    localparam logic [6:0]     BURST_MAX  = 7'(FIFO_LENGTH);

    writer_state_t             r_state;
    writer_state_t             w_next_state;
    logic [29:0]               r_base;
    logic [BUFF_ADDR_BITS-1:0] r_rd_ptr;
    logic [6:0]                r_burst_cnt;
    logic [WCW-1:0]            r_words_done;

    logic                      w_accept;
    logic                      w_push;
    logic                      w_burst_end;
    logic [WCW-1:0]            w_burst_start_word;

    // A start is only honoured while idle; a push happens on every fill cycle
    // the FIFO has room. The burst closes on the push that makes either the
    // burst or the whole line complete, so the command follows the last push
    // on the very next cycle.
    assign w_accept    = (r_state == ST_IDLE) && os_start;
    assign w_push      = (r_state == ST_FILL) && !port_wr_full;
    assign w_burst_end = w_push &&
                         (((r_burst_cnt + 7'd1) == BURST_MAX) ||
                          ((r_words_done + WCW'(1)) == WORDS_LAST));

    // The burst just filled started this many words into the line
    assign w_burst_start_word = r_words_done - WCW'(r_burst_cnt);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. Calibration is only looked at before the first burst;
    // once a transfer is running it is not re-checked.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_WAIT_CAL;
                end
            end
            ST_WAIT_CAL: begin
                if (mem_calib_done) begin
                    w_next_state = ST_PRIME;
                end
            end
            ST_PRIME: begin
                w_next_state = ST_FILL;
            end
            ST_FILL: begin
                if (w_burst_end) begin
                    w_next_state = ST_CMD;
                end
            end
            ST_CMD: begin
                if (r_words_done == WORDS_LAST) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_PRIME;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Burst counter, read pointer and address base. The read pointer always
    // names the word currently present on data_in; the prime cycle exists so
    // the buffer's one-cycle latency is absorbed before each burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_base       <= '0;
            r_rd_ptr     <= '0;
            r_burst_cnt  <= '0;
            r_words_done <= '0;
        end else begin
            if (w_accept) begin
                r_base       <= init_mem_addr & ~30'h3;
                r_rd_ptr     <= '0;
                r_words_done <= '0;
            end else if (w_push) begin
                r_rd_ptr     <= r_rd_ptr + BUFF_ADDR_BITS'(1);
                r_words_done <= r_words_done + WCW'(1);
            end

            if (r_state == ST_PRIME) begin
                r_burst_cnt <= '0;
            end else if (w_push) begin
                r_burst_cnt <= r_burst_cnt + 7'd1;
            end
        end
    end

    // Output logic. The buffer address looks one word ahead on a push so the
    // next word is already on data_in when the following cycle begins; during
    // a full-FIFO stall the address, and therefore data_in, stays put.
    always_comb begin
        busy_unit          = (r_state != ST_IDLE);
        data_in__addr      = r_rd_ptr + BUFF_ADDR_BITS'(w_push);
        port_wr_en         = w_push;
        port_wr_data_out   = '0;
        port_cmd_instr     = MCB_INSTR_WR;
        port_cmd_en        = 1'b0;
        port_cmd_bl        = '0;
        port_cmd_byte_addr = '0;

        if (w_push) begin
            port_wr_data_out = data_in;
        end

        if (r_state == ST_CMD) begin
            port_cmd_en        = 1'b1;
            port_cmd_bl        = 6'(r_burst_cnt - 7'd1);
            port_cmd_byte_addr = r_base +
                                 (30'(w_burst_start_word) * 30'(BYTES_PER_WORD));
        end
    end

`ifdef MEM_LINE_WRITER_STATS_EN
    logic [15:0] r_stall_cycles;

    // Counts fill cycles that could not push because the FIFO was full,
    // saturating rather than wrapping so a long stall is never under-reported
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (w_accept) begin
            r_stall_cycles <= '0;
        end else if ((r_state == ST_FILL) && port_wr_full &&
                     (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: doc/mem_line_writer.md
# mem_line_writer

Burst writer that moves one video line from an on-chip line buffer into DDR2 through one MCB user port. It is the write-direction counterpart of the line read dispatcher used by the display path. On `os_start`, it reads `WORDS_TO_WRITE` 32-bit words from the buffer, fills the MCB write FIFO, and issues one write command per burst. It sits in the `c3_clk0` domain, beside the read dispatcher. Its first use is storing the processed/background frame lines on port 3.

## Interface
- `FIFO_LENGTH`, default 64: maximum words per burst; legal range 1..64 (MCB `bl` field is 6 bits).
- `WORDS_TO_WRITE`, default 640: words per line transfer.
- `BUFF_ADDR_BITS`, default 10: line-buffer address width; 2^BUFF_ADDR_BITS ≥ WORDS_TO_WRITE.
- `clk` in 1: MCB user clock (`c3_clk0`). Single clock domain.
- `reset` in 1: synchronous, active-high.
- `os_start` in 1: one-shot start pulse.
- `init_mem_addr` in 30: DDR byte address of word 0; bits [1:0] are ignored (treated as 0).
- `busy_unit` out 1: high from accepted start until the last command is issued.
- `data_in__addr` out BUFF_ADDR_BITS: line-buffer read address; buffer read is synchronous, 1-cycle latency.
- `data_in` in 32: line-buffer read data.
- `mem_calib_done` in 1: MCB calibration complete.
- `port_cmd_en` out 1: command strobe.
- `port_cmd_instr` out 3: constant 3'b000 (write).
- `port_cmd_bl` out 6: burst length minus 1.
- `port_cmd_byte_addr` out 30: burst start byte address.
- `port_wr_en` out 1: write-FIFO push.
- `port_wr_data_out` out 32: write-FIFO data.
- `port_wr_full` in 1: write FIFO full.

## Operation
- States: IDLE, WAIT_CAL, PRIME, FILL, CMD.
- IDLE:
  - `os_start`=1 latches `init_mem_addr` with [1:0] cleared.
  - Clears `rd_ptr` and `words_done`, sets `busy_unit`, and goes to WAIT_CAL.
  - `os_start` in any other state is ignored.
- WAIT_CAL → PRIME when `mem_calib_done`=1.
  - Calibration is sampled only here; a drop mid-transfer is not monitored.
- PRIME: one cycle so that `data_in` reflects `rd_ptr`. Clears `burst_cnt`, then → FILL.
- Read address and push:
  - `data_in__addr` = `rd_ptr` + (push ? 1 : 0), combinational lookahead.
  - `data_in` therefore always holds word `rd_ptr`, giving one word per cycle.
- FILL:
  - push = !`port_wr_full`.
  - On push:
    - `port_wr_en`=1 and `port_wr_data_out`=`data_in`.
    - `rd_ptr`, `burst_cnt` and `words_done` each increment by 1.
  - The burst ends when `burst_cnt` reaches FIFO_LENGTH or `words_done` reaches WORDS_TO_WRITE, then → CMD.
- CMD:
  - One-cycle `port_cmd_en` with `port_cmd_bl` = `burst_cnt`−1.
  - `port_cmd_byte_addr` = base + 4×(words_done − burst_cnt).
  - If `words_done` = WORDS_TO_WRITE → IDLE and `busy_unit`=0. Otherwise → PRIME.
- Last burst: when WORDS_TO_WRITE is not a multiple of FIFO_LENGTH, the final burst is WORDS_TO_WRITE mod FIFO_LENGTH words.
- Address arithmetic: 30-bit, wraps modulo 2^30. No range checking.

## Timing
- Reset values:
  - `busy_unit`, `port_cmd_en` and `port_wr_en` = 0.
  - `port_cmd_instr` = 3'b000, `port_cmd_bl` = 0, `port_cmd_byte_addr` = 0.
  - `port_wr_data_out` = 0 and `data_in__addr` = 0.
  - State = IDLE.
- Start latency, with calibration already done: `os_start` at cycle 0 → WAIT_CAL at 1, PRIME at 2, first `port_wr_en` at cycle 3.
- Full-rate burst: N pushes on consecutive cycles, then `port_cmd_en` on the cycle after the last push.
- `port_wr_full` stall: no push while high. `data_in__addr` and `data_in` are held, and resume on the first cycle full is low.
- Per-burst overhead: 2 cycles (CMD + PRIME).
- A 640-word line at FIFO_LENGTH 64 with no stalls takes 3 + 10×66 − 1 = 662 cycles from `os_start` to `busy_unit` falling.
- Reset mid-transfer: returns to IDLE next edge with all outputs at reset values. Words already pushed to the MCB FIFO are not flushed; the integrator resets the MCB port too.
- A start pulse arriving in the same cycle as the final CMD is ignored.

## Configuration
- `MEM_LINE_WRITER_STATS_EN` defined:
  - Adds output `stall_cycles` (16 bits).
  - Counts FILL cycles with `port_wr_full`=1, saturating at 16'hFFFF.
  - Cleared on reset and on each accepted `os_start`.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `mem_dispatcher_pkg`:
  - MCB instruction codes (WR=3'b000, RD=3'b001).
  - State enum for this block.
  - Bytes-per-word constant (4).
- Single module with no sub-module; the burst counter and address generator are a few registers.

## Test plan
- Nominal line: WORDS_TO_WRITE=640, FIFO_LENGTH=64, base 0x1000.
  - 10 commands, bl=63 each.
  - Addresses 0x1000, 0x1100, …, 0x1900.
  - 640 pushes with data equal to buffer contents in order; `busy_unit` falls 662 cycles after start.
- Partial burst: WORDS_TO_WRITE=100, FIFO_LENGTH=64, base 0x3 → bursts bl=63 at 0x0 and bl=35 at 0x100.
- Backpressure: `port_wr_full` high for 5 cycles mid-burst.
  - No `port_wr_en` during the stall and no duplicated or skipped words.
  - Completion is delayed by exactly 5 cycles; with the macro defined, `stall_cycles`=5.
- Calibration gate: `mem_calib_done`=0 for 20 cycles after `os_start` → no port activity until calibration rises, then nominal sequence.
- Ignored restart: second `os_start` during burst 3 → the sequence is unchanged and exactly 10 commands are issued.
- Reset mid-burst: `reset` at push 30 of burst 2.
  - All outputs return to reset values next cycle.
  - A new `os_start` then performs a clean full line from word 0.
